// File: rtl/imem_loader_if.sv
// imem_loader_if: control, word-stream and byte-write bus of the instruction memory loader
interface imem_loader_if;
  logic start;
  logic abort;
  logic [9:0] base_addr;
  logic [8:0] word_count;
  logic in_valid;
  logic [31:0] in_word;
  logic in_ready;
  logic mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic busy;
  logic done;
  logic error;
  logic [8:0] words_written;
  modport master (
    output start, abort, base_addr, word_count, in_valid, in_word,
    input in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_written
  );
  modport slave (
    input start, abort, base_addr, word_count, in_valid, in_word,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_written
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit words into a 1024x8 instruction memory as big-endian bytes
module imem_loader (
  input logic CLK,
  input logic RESET,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_WORD, WRITE, DONE, ERR} state_t;
  state_t state;
  logic [1:0] idx;
  logic [9:0] addr;
  logic [8:0] cnt;
  logic [8:0] ww;
  logic [31:0] word;
  logic [11:0] end_addr;
  assign end_addr = {2'b00, bus.base_addr} + {1'b0, bus.word_count, 2'b00};
  always_ff @(posedge CLK)
    if (RESET) begin
      state <= IDLE;
      idx <= 2'd0;
      addr <= 10'd0;
      cnt <= 9'd0;
      ww <= 9'd0;
      word <= 32'd0;
    end else if (bus.abort && state != IDLE) state <= IDLE;
    else case (state)
      IDLE: if (bus.start) begin
        if (bus.base_addr[1:0] != 2'd0 || end_addr > 12'd1024) state <= ERR;
        else begin
          state <= (bus.word_count == 9'd0) ? DONE : WAIT_WORD;
          addr <= bus.base_addr;
          cnt <= bus.word_count;
          ww <= 9'd0;
          idx <= 2'd0;
        end
      end
      WAIT_WORD: if (bus.in_valid) begin
        word <= bus.in_word;
        idx <= 2'd0;
        state <= WRITE;
      end
      WRITE: begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          ww <= ww + 9'd1;
          addr <= addr + 10'd4;
          state <= (ww + 9'd1 == cnt) ? DONE : WAIT_WORD;
        end
      end
      default: state <= IDLE;
    endcase
  // All outputs are decoded from registers only; the byte lane follows idx.
  assign bus.in_ready = state == WAIT_WORD;
  assign bus.mem_we = state == WRITE;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.error = state == ERR;
  assign bus.words_written = ww;
  assign bus.mem_addr = addr + {8'd0, idx};
  assign bus.mem_wdata = idx == 2'd0 ? word[31:24] : idx == 2'd1 ? word[23:16] :
                         idx == 2'd2 ? word[15:8] : word[7:0];
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: CLK clocks all state; RESET is sampled only on the rising edge of CLK.
REQ-002 SHALL have port CLK, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begin a load; honoured only in IDLE.
REQ-005 SHALL have port abort, input, 1 bit: cancel the load in progress.
REQ-006 SHALL have port base_addr, input, 10 bits: first byte address, sampled on an accepted start.
REQ-007 SHALL have port word_count, input, 9 bits: words to load, sampled on an accepted start.
REQ-008 SHALL have port in_valid, input, 1 bit: in_word holds a valid word.
REQ-009 SHALL have port in_word, input, 32 bits: instruction word.
REQ-010 SHALL have port in_ready, output, 1 bit: loader accepts a word.
REQ-011 SHALL have port mem_we, output, 1 bit: byte write strobe to the 1024x8 instruction memory.
REQ-012 SHALL have port mem_addr, output, 10 bits: byte address.
REQ-013 SHALL have port mem_wdata, output, 8 bits: byte data.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when a load completes.
REQ-016 SHALL have port error, output, 1 bit: one-cycle pulse when a start is rejected.
REQ-017 SHALL have port words_written, output, 9 bits: count of fully written words in the current or last load.

Function
REQ-018 SHALL implement states IDLE, WAIT_WORD, WRITE (byte index 0-3), DONE, ERR.
REQ-019 SHALL decode every output from registered state only, with no combinational input-to-output path.
REQ-020 SHALL accept a start in IDLE as follows: base_addr[1:0]!=0, or base_addr+4*word_count>1024, goes to ERR; word_count==0 goes to DONE; otherwise it goes to WAIT_WORD.
REQ-021 SHALL, on an accepted start, latch the address and count and clear words_written.
REQ-022 SHALL assert in_ready if and only if the state is WAIT_WORD.
REQ-023 SHALL treat a handshake (in_valid and in_ready high at a clock edge) as capturing in_word and moving to WRITE with byte index 0.
REQ-024 SHALL, in WRITE, hold mem_we=1 for exactly 4 consecutive cycles.
REQ-025 SHALL, in WRITE, write bytes big-endian: mem_addr=A+k with mem_wdata=word[31-8k:24-8k] for k=0..3, where A is the word's base address.
REQ-026 SHALL, after byte 3, increment words_written and advance the address by 4, then go to WAIT_WORD if words remain, otherwise to DONE.
REQ-027 SHALL have a latency such that a handshake at edge N gives mem_we high in cycles N+1..N+4 and in_ready high again in cycle N+5, for a throughput of 1 word per 5 cycles.
REQ-028 SHALL hold mem_we=0 outside WRITE; mem_addr and mem_wdata are don't-care there but SHALL be stable.
REQ-029 SHALL, in DONE, assert done=1 for one cycle and then go to IDLE.
REQ-030 SHALL, in ERR, assert error=1 for one cycle, make no memory writes, and then go to IDLE.
REQ-031 SHALL ignore start in any state other than IDLE.
REQ-032 SHALL, on abort in any state other than IDLE, go to IDLE on the next edge with no done and no error.
REQ-033 SHALL, when abort occurs in WRITE, write no further bytes after that edge.
REQ-034 SHALL leave words_written unchanged on abort.
REQ-035 SHALL, when abort and a handshake occur on the same edge, let abort win and discard the word.
REQ-036 SHALL never wrap the address past 1023; the REQ-020 check guarantees this.

Reset
REQ-037 SHALL, when RESET=1 at an edge, force IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, words_written=0.
REQ-038 SHALL apply reset in any state, including mid-WRITE, and suppress further writes from the next cycle.
REQ-039 SHALL give RESET priority over abort, start and the handshake.

Verification
REQ-040 SHALL cover a single word: start with base 0 and count 1, then in_word 0x00011020 -> writes (0,0x00), (1,0x01), (2,0x10), (3,0x20); done pulses; words_written=1.
REQ-041 SHALL cover back-to-back loading: base 4, count 3, in_valid held high -> 12 writes at addresses 4..15; in_ready high exactly 3 times, 5 cycles apart; done pulses once.
REQ-042 SHALL cover rejected starts: base 2 -> error pulse, no mem_we; base 1020 with count 2 -> error pulse; count 0 -> done the next cycle with no writes.
REQ-043 SHALL cover abort in WRITE at byte 1 -> exactly 2 writes issued; busy=0 the next cycle; no done; words_written unchanged.
REQ-044 SHALL cover RESET during WAIT_WORD with in_valid=1 -> no writes; all outputs at reset values; a new start with base 8 and count 1 loads correctly.
REQ-045 SHALL cover a start pulsed during WRITE -> ignored; the load completes with its original parameters.
